// File: rtl/shared_access_pkg.sv
// shared_access_pkg: shared types, default widths and index-width helper for the shared-access arbiter
package shared_access_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GIVE_START,
      WAIT_FINISH,
      REGISTER_DATA,
      GIVE_FINISH
   } state_t;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_N              = 32;
   localparam int DEF_M              = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Width needed to index n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search for the first set request at or above rr_ptr
module rr_priority_picker
   import shared_access_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] request,
   input  logic [IW-1:0]      rr_ptr,
   output logic               found,
   output logic [IW-1:0]      winner
);

   // Scan offsets from farthest to nearest so the closest set bit above rr_ptr ends up winning.
   always_comb begin
      found  = |request;
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (request[(int'(rr_ptr) + k) % NUM_REQ]) winner = IW'((int'(rr_ptr) + k) % NUM_REQ);
   end

endmodule

// File: rtl/shared_access_rr_arbiter.sv
// shared_access_rr_arbiter: round-robin sharing of one target state machine among NUM_REQ requesters
// Optional watchdog on the target wait is built when SHARED_ACCESS_TIMEOUT_EN is defined.
module shared_access_rr_arbiter
   import shared_access_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int N              = DEF_N,
   parameter int M              = DEF_M,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 sm_clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   start_request,
   output logic [NUM_REQ-1:0]   reset_start_request,
   output logic [NUM_REQ-1:0]   finish,
   input  logic [NUM_REQ*N-1:0] input_arguments,
   output logic [N-1:0]         output_arguments,
   output logic                 start_target,
   input  logic                 target_finished,
   input  logic [M-1:0]         in_received_data,
   output logic [NUM_REQ*M-1:0] received_data,
   output logic                 timeout_error
);

   localparam int IW = idx_width(NUM_REQ);

   state_t        state, state_nx;
   logic [IW-1:0] grant_idx, rr_ptr, winner;
   logic          found, wd_expired;

   rr_priority_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
      .request (start_request),
      .rr_ptr  (rr_ptr),
      .found   (found),
      .winner  (winner)
   );

   // State, latched grant and rotation pointer; the pointer moves past the served requester on finish.
   always_ff @(posedge sm_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && found) grant_idx <= winner;
         if (state == GIVE_FINISH) rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Per-requester result holding registers; only the granted slice is written, once per grant.
   always_ff @(posedge sm_clk or posedge reset) begin
      if (reset) received_data <= '0;
      else if (state == REGISTER_DATA) received_data[grant_idx*M +: M] <= in_received_data;
   end

   // Next-state logic; target_finished is only looked at while waiting for the target.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:          if (found) state_nx = GIVE_START;
         GIVE_START:    state_nx = WAIT_FINISH;
         WAIT_FINISH:   if (target_finished) state_nx = REGISTER_DATA;
                        else if (wd_expired) state_nx = GIVE_FINISH;
         REGISTER_DATA: state_nx = GIVE_FINISH;
         GIVE_FINISH:   state_nx = IDLE;
         default:       state_nx = IDLE;
      endcase
   end

`ifdef SHARED_ACCESS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] wd_cnt;
   logic          wd_timed_out;

   assign wd_expired = (state == WAIT_FINISH) && !target_finished && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog counter is zero outside WAIT_FINISH; the abort flag marks the GIVE_FINISH that follows an expiry.
   always_ff @(posedge sm_clk or posedge reset) begin
      if (reset) begin
         wd_cnt       <= '0;
         wd_timed_out <= 1'b0;
      end else begin
         wd_cnt       <= (state == WAIT_FINISH) ? wd_cnt + 1'b1 : '0;
         wd_timed_out <= wd_expired;
      end
   end

   assign timeout_error = (state == GIVE_FINISH) && wd_timed_out;
`else
   assign wd_expired    = 1'b0;
   assign timeout_error = 1'b0;
`endif

   assign start_target        = (state == GIVE_START);
   assign reset_start_request = (state == GIVE_START)  ? (NUM_REQ'(1) << grant_idx) : '0;
   assign finish              = (state == GIVE_FINISH) ? (NUM_REQ'(1) << grant_idx) : '0;
   assign output_arguments    = input_arguments[grant_idx*N +: N];

endmodule
